mmio_bus_controller: RTL
========================

// Module: mmio_bus_controller
// PURPOSE
//  Parametrised, registered CPU-to-peripheral bus controller. Decodes the CPU address into one-hot
//  slave selects: a default memory region plus N_SLAVES base/mask windows (LED, 7-seg, keyboard, VGA).
//  Runs a req/ack transaction with per-slave ready wait states, a read-data return mux, and an error
//  response for unmapped or timed-out accesses. Sits between the CPU MEM stage and the slave set.
// PARAMETERS
//  N_SLAVES    4        number of windowed slaves; memory is an extra slot at index N_SLAVES
//  ADDR_W      32       address width
//  DATA_W      32       data width
//  MEM_HI_BITS 16       memory region hit when cpu_addr[ADDR_W-1 -: MEM_HI_BITS] == 0
//  SLV_BASE    {32'h001f_ff00,32'h000f_ff20,32'h000f_ff10,32'h000f_ff00}  slave i base at [i*ADDR_W +: ADDR_W]
//  SLV_MASK    {4{32'hffff_fff0}}  slave i mask, same packing; hit when (addr & mask) == (base & mask)
//  TIMEOUT     16       max ACCESS cycles waiting for ready (>= 2)
// PORTS
//  clk        in   1                     system clock, rising edge
//  rst_n      in   1                     asynchronous reset, active low
//  cpu_req    in   1                     transaction request, level; sampled only in IDLE
//  cpu_addr   in   ADDR_W                address, valid with cpu_req
//  cpu_wdata  in   DATA_W                write data, valid with cpu_req
//  cpu_rw     in   1                     1 = write, 0 = read
//  cpu_ack    out  1                     one-cycle completion pulse
//  cpu_rdata  out  DATA_W                read data, valid while cpu_ack=1
//  cpu_err    out  1                     error flag, valid while cpu_ack=1
//  bus_sel    out  N_SLAVES+1            one-hot slave select; bit N_SLAVES = memory
//  bus_addr   out  ADDR_W                latched address to slaves
//  bus_wdata  out  DATA_W                latched write data to slaves
//  bus_rw     out  1                     latched rw to slaves
//  slv_rdata  in   (N_SLAVES+1)*DATA_W   slave read data, slot i at [i*DATA_W +: DATA_W]
//  slv_ready  in   N_SLAVES+1            slave i has completed the current access
// BEHAVIOUR
//  Reset: async on rst_n=0; state=IDLE; all outputs 0; wait counter 0. Reset mid-transaction aborts it,
//   so no cpu_ack is issued for the aborted access.
//  Decode priority: memory region first; then lowest-index window that hits; no hit -> unmapped.
//  FSM IDLE -> ACCESS -> RESP -> IDLE:
//   IDLE: on cpu_req=1 at edge k, latch addr/wdata/rw to bus_*. Mapped: bus_sel one-hot from cycle k+1,
//    state ACCESS, counter=0. Unmapped: bus_sel stays 0, state RESP with err=1, rdata=0 (ack in cycle k+1).
//   ACCESS: only slv_ready[sel index] is observed; other ready bits are ignored. Ready=1 at edge ->
//    capture slv_rdata of the selected slot (writes capture 0), clear bus_sel, go to RESP with err=0.
//    Otherwise increment counter; ready still 0 after TIMEOUT ACCESS cycles -> clear bus_sel, go to RESP
//    with err=1 and rdata=0. Ready on the last allowed cycle counts as success, not timeout.
//   RESP: cpu_ack=1, cpu_rdata/cpu_err held for exactly one cycle, then IDLE; cpu_req ignored in RESP.
//  Latency: zero-wait slave -> ack in cycle k+2; W wait cycles -> k+2+W; unmapped -> k+1.
//  Back-to-back: if cpu_req is still 1 in the first IDLE cycle after ack, a new transaction starts.
//   The CPU drops req in the ack cycle unless it issues another access.
//  bus_addr/bus_wdata/bus_rw hold their last values outside ACCESS; bus_sel is 0 outside ACCESS.
//  cpu_addr/wdata/rw changes after the sampling edge have no effect on the current transaction.
// CONFIGURATION
//  BUS_TIMEOUT_EN defined: timeout counter and the timeout error path exist, as described above.
//  BUS_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ready; cpu_err=1 only when
//   the address is unmapped. TIMEOUT is unused.
// TESTING
//  1 Reset: rst_n=0 mid-ACCESS -> outputs 0 immediately; no ack follows; next req decodes normally.
//  2 Write 0x000f_ff04, data 0xA5, slv_ready[0] tied 1 -> bus_sel=5'b00001 cycle k+1; ack cycle k+2, err=0.
//  3 Read 0x0000_1000, ready[4] after 3 waits, rdata slot4=0xDEADBEEF -> bus_sel=5'b10000; ack k+5,
//    cpu_rdata=0xDEADBEEF.
//  4 Read 0x0123_4560 (unmapped) -> bus_sel stays 0; ack cycle k+1, err=1, rdata=0.
//  5 Read 0x001f_ff08, ready[3] never set, TIMEOUT=16 -> sel 5'b01000 for 16 cycles; ack, err=1 (EN).
//    Without EN, sel stays high until ready.
//  6 Two reqs back-to-back (0x000f_ff10, then 0x000f_ff20), other ready bits toggling -> sel 00010 then 00100.
//    Each gets one ack; stray ready bits are ignored.

Source files
------------

// File: rtl/mmio_bus_controller.sv
// mmio_bus_controller: registered CPU-to-slave req/ack bus controller with window decode; define BUS_TIMEOUT_EN to enable the ready timeout
module mmio_bus_controller #(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_HI_BITS = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h001f_ff00, 32'h000f_ff20, 32'h000f_ff10, 32'h000f_ff00},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK = {4{32'hffff_fff0}},
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cpu_req,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_rw,
  output logic                         cpu_ack,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_err,
  output logic [N_SLAVES:0]            bus_sel,
  output logic [ADDR_W-1:0]            bus_addr,
  output logic [DATA_W-1:0]            bus_wdata,
  output logic                         bus_rw,
  input  logic [(N_SLAVES+1)*DATA_W-1:0] slv_rdata,
  input  logic [N_SLAVES:0]            slv_ready
);
  localparam int NS = N_SLAVES + 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic [NS-1:0] sel_dec, sel_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, rdata_nx, sel_rdata;
  logic rw_nx, err_nx, ready_hit, tmo;
  // memory region wins; otherwise the lowest-index hitting window (descending loop, last write wins)
  always_comb begin
    sel_dec = '0;
    if (cpu_addr[ADDR_W-1 -: MEM_HI_BITS] == '0) sel_dec[N_SLAVES] = 1'b1;
    else
      for (int i = N_SLAVES - 1; i >= 0; i--)
        if ((cpu_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))
          sel_dec = NS'(1) << i;
  end
  // read-data return mux driven by the one-hot select
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) sel_rdata = sel_rdata | (bus_sel[i] ? slv_rdata[i*DATA_W +: DATA_W] : '0);
  end
  assign ready_hit = |(slv_ready & bus_sel);
  assign cpu_ack = state == RESP;
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  assign tmo = cnt == CW'(TIMEOUT - 1);
  // counts ACCESS cycles spent waiting; zero whenever not in ACCESS
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
`else
  assign tmo = 1'b0;
`endif
  // next-state and next-register values for the IDLE -> ACCESS -> RESP handshake
  always_comb begin
    state_nx = state;
    sel_nx = bus_sel;
    addr_nx = bus_addr;
    wdata_nx = bus_wdata;
    rw_nx = bus_rw;
    rdata_nx = cpu_rdata;
    err_nx = cpu_err;
    case (state)
      IDLE:
        if (cpu_req) begin
          addr_nx = cpu_addr;
          wdata_nx = cpu_wdata;
          rw_nx = cpu_rw;
          sel_nx = sel_dec;
          state_nx = |sel_dec ? ACCESS : RESP;
          err_nx = ~|sel_dec;
          rdata_nx = '0;
        end
      ACCESS:
        if (ready_hit || tmo) begin
          sel_nx = '0;
          state_nx = RESP;
          err_nx = ~ready_hit;
          rdata_nx = (ready_hit && !bus_rw) ? sel_rdata : '0;
        end
      default: begin
        state_nx = IDLE;
        rdata_nx = '0;
        err_nx = 1'b0;
      end
    endcase
  end
  // state and all registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus_sel <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      bus_rw <= 1'b0;
      cpu_rdata <= '0;
      cpu_err <= 1'b0;
    end else begin
      state <= state_nx;
      bus_sel <= sel_nx;
      bus_addr <= addr_nx;
      bus_wdata <= wdata_nx;
      bus_rw <= rw_nx;
      cpu_rdata <= rdata_nx;
      cpu_err <= err_nx;
    end
endmodule
